// File: rtl/uart_sid_rx_if.sv
// Register bus between a host and the SID-checking UART receiver.
// Master drives strobe/address/write data; the receiver returns read data.
interface uart_sid_rx_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output we_i,
    output addr_i,
    output data_i,
    input  data_o
  );

  modport slave (
    input  we_i,
    input  addr_i,
    input  data_i,
    output data_o
  );
endinterface

// File: rtl/uart_sid_rx.sv
// 8N1 UART receiver with W1C status, overrun/framing flags
// and a single-step-restart matcher for a fixed SID string.
module uart_sid_rx #(
  parameter logic [15:0]          BAUD_DEFAULT = 16'h1B8,
  parameter int                   SID_LEN      = 10,
  parameter logic [8*SID_LEN-1:0] SID_STR      = 80'h32303234323131303533
) (
  input  logic         clk,
  input  logic         rst,
  uart_sid_rx_if.slave bus,
  input  logic         rx_pin,
  output logic         rx_valid_o,
  output logic         sid_match_o
);

  localparam int IW = $clog2(SID_LEN);
  localparam logic [IW-1:0] LAST = IW'(SID_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state, state_n;
  logic [15:0]   cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          sync_q1, sync_q2;
  logic [1:0]    ctrl;
  logic [3:0]    status, status_n;
  logic [15:0]   baud;
  logic [7:0]    rxdata;
  logic [IW-1:0] sidcnt, sidcnt_n;
  logic          rx_valid_r;
  logic          sid_pend, sid_hit;
  logic          sid_match_r;
  logic          good, ferr;
  logic [31:0]   rdata;

  logic          rx_en, match_en;
  logic          fall, tick, half;
  logic [7:0]    a8;
  logic          wr_ctrl, wr_stat, wr_baud;
  logic [3:0]    w1c;
  logic          unused;

  assign rx_en    = ctrl[0];
  assign match_en = ctrl[1];
  // q1 is the newer sample: line just went low while q2 still high
  assign fall     = ~sync_q1 & sync_q2;
  assign tick     = (cnt == baud);
  assign half     = (cnt == (baud >> 1));

  assign a8      = bus.addr_i[7:0];
  assign wr_ctrl = bus.we_i & (a8 == 8'h00);
  assign wr_stat = bus.we_i & (a8 == 8'h04);
  assign wr_baud = bus.we_i & (a8 == 8'h08);
  assign w1c     = wr_stat ? bus.data_i[3:0] : 4'h0;
  assign unused  = ^{bus.addr_i[31:8], bus.data_i[31:16]};

  function automatic logic [7:0] char_at(input logic [IW-1:0] i);
    return SID_STR[8*(SID_LEN-1-int'(i)) +: 8];
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    idx_n   = idx;
    shift_n = shift;
    good    = 1'b0;
    ferr    = 1'b0;
    if (!rx_en) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          cnt_n = '0;
          idx_n = '0;
          if (fall) state_n = S_START;
        end
        S_START: begin
          if (half) begin
            cnt_n   = '0;
            state_n = sync_q2 ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (tick) begin
            cnt_n        = '0;
            shift_n[idx] = sync_q2;
            idx_n        = idx + 3'd1;
            if (idx == 3'd7) state_n = S_STOP;
          end
        end
        S_STOP: begin
          if (tick) begin
            cnt_n   = '0;
            state_n = S_IDLE;
            good    = sync_q2;
            ferr    = ~sync_q2;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sidcnt_n = sidcnt;
    sid_hit  = 1'b0;
    if (!match_en) begin
      sidcnt_n = '0;
    end else if (good) begin
      if (shift == char_at(sidcnt)) begin
        if (sidcnt == LAST) begin
          sidcnt_n = '0;
          sid_hit  = 1'b1;
        end else begin
          sidcnt_n = sidcnt + 1'b1;
        end
      end else begin
        sidcnt_n = (shift == char_at('0)) ? IW'(1) : '0;
      end
    end
    if (ferr) sidcnt_n = '0;
  end

  // hardware set wins over a same-cycle W1C
  always_comb begin
    status_n = (status & ~w1c)
             | {sid_pend, good & status[0], ferr, good};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q1     <= 1'b1;
      sync_q2     <= 1'b1;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      ctrl        <= '0;
      status      <= '0;
      baud        <= BAUD_DEFAULT;
      rxdata      <= '0;
      sidcnt      <= '0;
      rx_valid_r  <= 1'b0;
      sid_pend    <= 1'b0;
      sid_match_r <= 1'b0;
    end else begin
      sync_q1     <= rx_pin;
      sync_q2     <= sync_q1;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shift       <= shift_n;
      status      <= status_n;
      sidcnt      <= sidcnt_n;
      rx_valid_r  <= good;
      sid_pend    <= sid_hit;
      sid_match_r <= sid_pend;
      if (good)    rxdata <= shift;
      if (wr_ctrl) ctrl   <= bus.data_i[1:0];
      if (wr_baud) baud   <= bus.data_i[15:0];
    end
  end

  always_comb begin
    rdata = '0;
    if (rst) begin
      unique case (1'b1)
        (a8 == 8'h00): rdata = {30'h0, ctrl};
        (a8 == 8'h04): rdata = {28'h0, status};
        (a8 == 8'h08): rdata = {16'h0, baud};
        (a8 == 8'h10): rdata = {24'h0, rxdata};
        (a8 == 8'h14): rdata = 32'(sidcnt);
        default:       rdata = '0;
      endcase
    end
  end

  assign bus.data_o  = rdata;
  assign rx_valid_o  = rx_valid_r;
  assign sid_match_o = sid_match_r;

endmodule

// File: tb/tb_uart_sid_rx.sv
// Directed bench for uart_sid_rx at 16 clk/bit: framing,
// glitch rejection, overrun, W1C races, SID matching, disable/reset.
module tb_uart_sid_rx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_pin = 1'b1;
  logic rx_valid_o, sid_match_o;

  uart_sid_rx_if bus ();

  uart_sid_rx dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .rx_pin     (rx_pin),
    .rx_valid_o (rx_valid_o),
    .sid_match_o(sid_match_o)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  int   vcnt = 0;
  int   mcnt = 0;
  logic prev_v = 1'b0;
  logic match_adj = 1'b0;

  logic [7:0] sid [10] = '{8'h32, 8'h30, 8'h32, 8'h34, 8'h32,
                           8'h31, 8'h31, 8'h30, 8'h35, 8'h33};

  always @(negedge clk) begin
    if (rx_valid_o) vcnt++;
    if (sid_match_o) begin
      mcnt++;
      match_adj = prev_v;
    end
    prev_v = rx_valid_o;
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    bus.we_i   = 1'b1;
    bus.addr_i = {24'h0, a};
    bus.data_i = d;
    @(negedge clk);
    bus.we_i   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    bus.addr_i = {24'h0, a};
    #1;
    d = bus.data_o;
  endtask

  // w1c_at_set: write STATUS=w1c_val on the stop-sample edge
  task automatic send(input logic [7:0] b, input logic stop,
                      input logic w1c_at_set, input logic [31:0] w1c_val);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_pin = frame[i];
      if (i == 9 && w1c_at_set) begin
        repeat (9) @(negedge clk);
        wr(8'h04, w1c_val);
        repeat (6) @(negedge clk);
      end else begin
        repeat (16) @(negedge clk);
      end
    end
    rx_pin = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clk);
    rd(8'h08, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL rst_low_read: got %h want %h", d, 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    rd(8'h00, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL rst_ctrl: got %h want %h", d, 32'h0);
    end
    rd(8'h04, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL rst_status: got %h want %h", d, 32'h0);
    end
    rd(8'h08, d);
    n_chk++;
    if (d !== 32'h1B8) begin
      n_fail++; $display("FAIL rst_baud: got %h want %h", d, 32'h1B8);
    end
    rd(8'h10, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL rst_rxdata: got %h want %h", d, 32'h0);
    end
    rd(8'h0C, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_read: got %h want %h", d, 32'h0);
    end
    n_chk++;
    if ({rx_valid_o, sid_match_o} !== 2'b00) begin
      n_fail++; $display("FAIL rst_outputs: got %b want 00", {rx_valid_o, sid_match_o});
    end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] d;
    int v0;
    wr(8'h08, 32'd15);
    wr(8'h00, 32'd3);
    rd(8'h08, d);
    n_chk++;
    if (d !== 32'd15) begin
      n_fail++; $display("FAIL baud_wr: got %h want %h", d, 32'd15);
    end
    v0 = vcnt;
    send(8'h55, 1'b1, 1'b0, 32'h0);
    n_chk++;
    if (vcnt - v0 !== 1) begin
      n_fail++; $display("FAIL basic_pulses: got %0d want 1", vcnt - v0);
    end
    rd(8'h10, d);
    n_chk++;
    if (d !== 32'h55) begin
      n_fail++; $display("FAIL basic_rxdata: got %h want %h", d, 32'h55);
    end
    rd(8'h04, d);
    n_chk++;
    if (d !== 32'h1) begin
      n_fail++; $display("FAIL basic_status: got %h want %h", d, 32'h1);
    end
    wr(8'h04, 32'h1);
    rd(8'h04, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL basic_w1c: got %h want %h", d, 32'h0);
    end
  endtask

  task automatic test_frame();
    logic [31:0] d;
    int v0;
    v0 = vcnt;
    send(8'hA5, 1'b0, 1'b0, 32'h0);
    repeat (20) @(negedge clk);
    n_chk++;
    if (vcnt - v0 !== 0) begin
      n_fail++; $display("FAIL frame_pulses: got %0d want 0", vcnt - v0);
    end
    rd(8'h04, d);
    n_chk++;
    if (d !== 32'h2) begin
      n_fail++; $display("FAIL frame_status: got %h want %h", d, 32'h2);
    end
    rd(8'h10, d);
    n_chk++;
    if (d !== 32'h55) begin
      n_fail++; $display("FAIL frame_rxdata: got %h want %h", d, 32'h55);
    end
    wr(8'h04, 32'hF);
    rx_pin = 1'b0;
    repeat (4) @(negedge clk);
    rx_pin = 1'b1;
    repeat (200) @(negedge clk);
    n_chk++;
    if (vcnt - v0 !== 0) begin
      n_fail++; $display("FAIL glitch_pulses: got %0d want 0", vcnt - v0);
    end
    rd(8'h04, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL glitch_status: got %h want %h", d, 32'h0);
    end
  endtask

  task automatic test_sid();
    logic [31:0] d;
    int m0, v0;
    m0 = mcnt;
    v0 = vcnt;
    for (int i = 0; i < 10; i++) begin
      send(sid[i], 1'b1, 1'b0, 32'h0);
      rd(8'h14, d);
      n_chk++;
      if (d !== 32'((i + 1) % 10)) begin
        n_fail++; $display("FAIL sid_cnt[%0d]: got %0d want %0d", i, d, (i + 1) % 10);
      end
    end
    n_chk++;
    if (mcnt - m0 !== 1 || vcnt - v0 !== 10) begin
      n_fail++; $display("FAIL sid_pulses: got match=%0d valid=%0d want 1/10",
                         mcnt - m0, vcnt - v0);
    end
    n_chk++;
    if (match_adj !== 1'b1) begin
      n_fail++; $display("FAIL sid_latency: got %b want 1", match_adj);
    end
    rd(8'h04, d);
    n_chk++;
    if (d[3] !== 1'b1) begin
      n_fail++; $display("FAIL sid_status: got %h want bit3 set", d);
    end
  endtask

  task automatic test_restart();
    logic [31:0] d;
    int m0;
    logic [7:0] pre [4] = '{8'h32, 8'h30, 8'h32, 8'h39};
    m0 = mcnt;
    for (int i = 0; i < 4; i++) send(pre[i], 1'b1, 1'b0, 32'h0);
    rd(8'h14, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL restart_2029: got %0d want 0", d);
    end
    for (int i = 0; i < 10; i++) send(sid[i], 1'b1, 1'b0, 32'h0);
    n_chk++;
    if (mcnt - m0 !== 1) begin
      n_fail++; $display("FAIL restart_match1: got %0d want 1", mcnt - m0);
    end
    m0 = mcnt;
    send(8'h32, 1'b1, 1'b0, 32'h0);
    send(8'h32, 1'b1, 1'b0, 32'h0);
    rd(8'h14, d);
    n_chk++;
    if (d !== 32'h1) begin
      n_fail++; $display("FAIL restart_22: got %0d want 1", d);
    end
    for (int i = 1; i < 10; i++) send(sid[i], 1'b1, 1'b0, 32'h0);
    n_chk++;
    if (mcnt - m0 !== 1) begin
      n_fail++; $display("FAIL restart_match2: got %0d want 1", mcnt - m0);
    end
    rd(8'h14, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL restart_cnt: got %0d want 0", d);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    wr(8'h04, 32'hF);
    send(8'h11, 1'b1, 1'b0, 32'h0);
    send(8'h22, 1'b1, 1'b0, 32'h0);
    rd(8'h04, d);
    n_chk++;
    if (d !== 32'h5) begin
      n_fail++; $display("FAIL ovr_status: got %h want %h", d, 32'h5);
    end
    rd(8'h10, d);
    n_chk++;
    if (d !== 32'h22) begin
      n_fail++; $display("FAIL ovr_rxdata: got %h want %h", d, 32'h22);
    end
    wr(8'h04, 32'hF);
    send(8'h3C, 1'b1, 1'b1, 32'h1);
    rd(8'h04, d);
    n_chk++;
    if (d !== 32'h1) begin
      n_fail++; $display("FAIL w1c_race: got %h want %h", d, 32'h1);
    end
    rd(8'h10, d);
    n_chk++;
    if (d !== 32'h3C) begin
      n_fail++; $display("FAIL w1c_rxdata: got %h want %h", d, 32'h3C);
    end
  endtask

  task automatic test_disable();
    logic [31:0] d;
    int v0;
    wr(8'h04, 32'hF);
    v0 = vcnt;
    rx_pin = 1'b0;
    repeat (16) @(negedge clk);
    rx_pin = 1'b1;
    repeat (32) @(negedge clk);
    wr(8'h00, 32'h2);
    repeat (200) @(negedge clk);
    n_chk++;
    if (vcnt - v0 !== 0) begin
      n_fail++; $display("FAIL dis_pulses: got %0d want 0", vcnt - v0);
    end
    rd(8'h04, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL dis_status: got %h want %h", d, 32'h0);
    end
    wr(8'h00, 32'h3);
    send(8'h5A, 1'b1, 1'b0, 32'h0);
    rd(8'h10, d);
    n_chk++;
    if (d !== 32'h5A || vcnt - v0 !== 1) begin
      n_fail++; $display("FAIL dis_recover: got %h/%0d want 5a/1", d, vcnt - v0);
    end
  endtask

  task automatic test_rst_mid();
    logic [31:0] d;
    int v0;
    send(8'h32, 1'b1, 1'b0, 32'h0);
    rd(8'h14, d);
    n_chk++;
    if (d !== 32'h1) begin
      n_fail++; $display("FAIL pre_rst_cnt: got %0d want 1", d);
    end
    v0 = vcnt;
    rx_pin = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rd(8'h10, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst_read: got %h want %h", d, 32'h0);
    end
    rx_pin = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rd(8'h00, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst_ctrl: got %h want %h", d, 32'h0);
    end
    rd(8'h08, d);
    n_chk++;
    if (d !== 32'h1B8) begin
      n_fail++; $display("FAIL mid_rst_baud: got %h want %h", d, 32'h1B8);
    end
    rd(8'h10, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst_rxdata: got %h want %h", d, 32'h0);
    end
    rd(8'h14, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst_sidcnt: got %h want %h", d, 32'h0);
    end
    rd(8'h04, d);
    n_chk++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst_status: got %h want %h", d, 32'h0);
    end
    repeat (200) @(negedge clk);
    n_chk++;
    if (vcnt - v0 !== 0) begin
      n_fail++; $display("FAIL mid_rst_pulses: got %0d want 0", vcnt - v0);
    end
  endtask

  initial begin
    bus.we_i   = 1'b0;
    bus.addr_i = '0;
    bus.data_i = '0;
    test_reset();
    test_basic();
    test_frame();
    test_sid();
    test_restart();
    test_overrun();
    test_disable();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
